// File: rtl/regfile_pkg.sv
// Shared constants, typedefs and the write-port hit helper for the
// scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_D = 32;
  localparam int unsigned NREG_D = 32;
  localparam int unsigned AW_D   = $clog2(NREG_D);

  // Helper operates on padded vectors so one function serves every configuration
  localparam int unsigned MAX_AW = 8;
  localparam int unsigned MAX_NW = 2;

  typedef logic [AW_D-1:0]   reg_addr_t;
  typedef logic [XLEN_D-1:0] reg_data_t;

  typedef struct packed {
    logic       valid;
    logic [0:0] idx;
  } wr_hit_t;

  // Highest-index enabled write port targeting a nonzero addr
  function automatic wr_hit_t wr_hit(input logic [MAX_AW-1:0]             addr,
                                     input logic [MAX_NW-1:0]             we,
                                     input logic [MAX_NW-1:0][MAX_AW-1:0] wa);
    wr_hit_t h;
    h = '0;
    for (int unsigned k = 0; k < MAX_NW; k++) begin
      if (we[k] && (addr != '0) && (wa[k] == addr)) begin
        h.valid = 1'b1;
        h.idx   = 1'(k);
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/allocate bundle between issue, writeback and the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_D,
  parameter int unsigned NREG = NREG_D,
  parameter int unsigned NR   = 2,
  parameter int unsigned NW   = 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NR-1:0][AW-1:0]   rs_addr_i;
  logic [NR-1:0][XLEN-1:0] rs_data_o;
  logic [NR-1:0]           rs_ready_o;
  logic [NW-1:0]           we_i;
  logic [NW-1:0][AW-1:0]   wa_i;
  logic [NW-1:0][XLEN-1:0] wd_i;
  logic                    alloc_valid_i;
  logic [AW-1:0]           alloc_addr_i;
  logic                    flush_i;
  logic [NREG-1:0]         busy_o;

  modport master (
    output rs_addr_i, we_i, wa_i, wd_i, alloc_valid_i, alloc_addr_i, flush_i,
    input  rs_data_o, rs_ready_o, busy_o
  );

  modport slave (
    input  rs_addr_i, we_i, wa_i, wd_i, alloc_valid_i, alloc_addr_i, flush_i,
    output rs_data_o, rs_ready_o, busy_o
  );

endinterface

// File: rtl/regfile_sb_score.sv
// Busy-bit scoreboard: flush beats allocate, allocate beats writeback clear.
module regfile_sb_score
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_D,
  parameter int unsigned NW   = 1,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NW-1:0]         we_i,
  input  logic [NW-1:0][AW-1:0] wa_i,
  input  logic                  alloc_valid_i,
  input  logic [AW-1:0]         alloc_addr_i,
  input  logic                  flush_i,
  output logic [NREG-1:0]       busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Later statements override earlier ones, giving the priority order
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NW; k++) begin
      if (we_i[k] && (wa_i[k] != '0)) busy_d[wa_i[k]] = 1'b0;
    end
    if (alloc_valid_i && (alloc_addr_i != '0)) busy_d[alloc_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file (x0 hardwired) with optional same-cycle
// write bypass and a busy scoreboard for RAW stalls.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned NREG   = NREG_D,
  parameter int unsigned NR     = 2,
  parameter int unsigned NW     = 1,
  parameter bit          BYPASS = 1'b1
) (
  input logic         clk_i,
  input logic         rst_ni,
  regfile_sb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [NREG-1:0] busy;

  regfile_sb_score #(
    .NREG (NREG),
    .NW   (NW),
    .AW   (AW)
  ) u_score (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .we_i          (bus.we_i),
    .wa_i          (bus.wa_i),
    .alloc_valid_i (bus.alloc_valid_i),
    .alloc_addr_i  (bus.alloc_addr_i),
    .flush_i       (bus.flush_i),
    .busy_o        (busy)
  );

  assign bus.busy_o = busy;

  // Write ports padded to helper width; masked in reset so nothing forwards
  logic [MAX_NW-1:0]             we_pad;
  logic [MAX_NW-1:0][MAX_AW-1:0] wa_pad;
  logic [XLEN-1:0]               wd_pad [MAX_NW];

  always_comb begin
    we_pad = '0;
    wa_pad = '0;
    for (int unsigned k = 0; k < MAX_NW; k++) wd_pad[k] = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      we_pad[k] = bus.we_i[k] & rst_ni;
      wa_pad[k] = MAX_AW'(bus.wa_i[k]);
      wd_pad[k] = bus.wd_i[k];
    end
  end

  logic [XLEN-1:0] arr [NREG];

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign arr[r] = '0;
    end else begin : g_store
      wr_hit_t         hit;
      logic [XLEN-1:0] q;

      assign hit = wr_hit(MAX_AW'(r), we_pad, wa_pad);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        q <= '0;
        else if (hit.valid) q <= wd_pad[hit.idx];
      end

      assign arr[r] = q;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0] a;
    wr_hit_t       hit;
    logic          fwd;

    assign a   = bus.rs_addr_i[p];
    assign hit = wr_hit(MAX_AW'(a), we_pad, wa_pad);
    assign fwd = BYPASS && hit.valid;

    assign bus.rs_data_o[p]  = fwd ? wd_pad[hit.idx] : arr[a];
    assign bus.rs_ready_o[p] = !busy[a] || fwd;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench driving a bypassing and a non-bypassing register file in lockstep.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;

  logic [1:0][4:0]  rs_addr;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic             alloc_valid;
  logic [4:0]       alloc_addr;
  logic             flush;

  int checks   = 0;
  int failures = 0;

  regfile_sb_if #(.XLEN(32), .NREG(32), .NR(2), .NW(2)) b1 ();
  regfile_sb_if #(.XLEN(32), .NREG(32), .NR(2), .NW(2)) b0 ();

  assign b1.rs_addr_i     = rs_addr;
  assign b1.we_i          = we;
  assign b1.wa_i          = wa;
  assign b1.wd_i          = wd;
  assign b1.alloc_valid_i = alloc_valid;
  assign b1.alloc_addr_i  = alloc_addr;
  assign b1.flush_i       = flush;

  assign b0.rs_addr_i     = rs_addr;
  assign b0.we_i          = we;
  assign b0.wa_i          = wa;
  assign b0.wd_i          = wd;
  assign b0.alloc_valid_i = alloc_valid;
  assign b0.alloc_addr_i  = alloc_addr;
  assign b0.flush_i       = flush;

  regfile_sb #(.XLEN(32), .NREG(32), .NR(2), .NW(2), .BYPASS(1'b1)) u_byp (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b1)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .NR(2), .NW(2), .BYPASS(1'b0)) u_nob (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = '0;
    wa          = '0;
    wd          = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    flush       = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rs_addr = '0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Activity before a mid-stream reset
    we[0] = 1'b1; wa[0] = 5'd12; wd[0] = 32'hAAAA_0012;
    alloc_valid = 1'b1; alloc_addr = 5'd13;
    cyc();
    idle();
    rs_addr[0] = 5'd12; rs_addr[1] = 5'd13;
    #1;
    chk("pre_rst_data_nob", 64'(b0.rs_data_o[0]), 64'hAAAA_0012);
    chk("pre_rst_busy",     64'(b1.busy_o),       64'h0000_2000);
    chk("pre_rst_ready",    64'(b1.rs_ready_o),   64'h1);

    // Reset lands while a write and an allocation are pending
    we[0] = 1'b1; wa[0] = 5'd14; wd[0] = 32'h0000_1414;
    alloc_valid = 1'b1; alloc_addr = 5'd15;
    rs_addr[1] = 5'd14;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data0_byp", 64'(b1.rs_data_o[0]), 64'h0);
    chk("rst_data1_byp", 64'(b1.rs_data_o[1]), 64'h0);
    chk("rst_ready_byp", 64'(b1.rs_ready_o),   64'h3);
    chk("rst_busy_byp",  64'(b1.busy_o),       64'h0);
    chk("rst_data0_nob", 64'(b0.rs_data_o[0]), 64'h0);
    chk("rst_ready_nob", 64'(b0.rs_ready_o),   64'h3);
    cyc();
    idle();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_x12",  64'(b1.rs_data_o[0]), 64'h0);
    chk("post_rst_x14",  64'(b0.rs_data_o[1]), 64'h0);
    chk("post_rst_busy", 64'(b0.busy_o),       64'h0);

    // Write x5 while reading it
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd0;
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
    #1;
    chk("x5_same_byp", 64'(b1.rs_data_o[0]), 64'hDEAD_BEEF);
    chk("x5_same_nob", 64'(b0.rs_data_o[0]), 64'h0);
    chk("x0_port1",    64'(b1.rs_data_o[1]), 64'h0);
    cyc();
    idle();
    #1;
    chk("x5_next_nob", 64'(b0.rs_data_o[0]), 64'hDEAD_BEEF);
    chk("x5_next_byp", 64'(b1.rs_data_o[0]), 64'hDEAD_BEEF);

    // Both ports write x7; port 1 wins
    rs_addr[0] = 5'd7;
    we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22;
    #1;
    chk("x7_same_byp", 64'(b1.rs_data_o[0]), 64'h22);
    cyc();
    idle();
    #1;
    chk("x7_next_nob", 64'(b0.rs_data_o[0]), 64'h22);
    chk("x7_next_byp", 64'(b1.rs_data_o[0]), 64'h22);

    // Write and allocate x0
    rs_addr[0] = 5'd0; rs_addr[1] = 5'd0;
    we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'hFFFF_FFFF;
    alloc_valid = 1'b1; alloc_addr = 5'd0;
    #1;
    chk("x0_same_byp",  64'(b1.rs_data_o[1]), 64'h0);
    chk("x0_ready_byp", 64'(b1.rs_ready_o),   64'h3);
    cyc();
    idle();
    #1;
    chk("x0_next_nob", 64'(b0.rs_data_o[1]), 64'h0);
    chk("x0_busy_byp", 64'(b1.busy_o),       64'h0);
    chk("x0_busy_nob", 64'(b0.busy_o),       64'h0);

    // Allocate x9, stall three cycles, then write it back
    rs_addr[1] = 5'd9;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("x9_stall_byp", 64'(b1.rs_ready_o[1]), 64'h0);
      chk("x9_stall_nob", 64'(b0.rs_ready_o[1]), 64'h0);
      cyc();
    end
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h55;
    #1;
    chk("x9_wb_ready_byp", 64'(b1.rs_ready_o[1]), 64'h1);
    chk("x9_wb_data_byp",  64'(b1.rs_data_o[1]),  64'h55);
    chk("x9_wb_ready_nob", 64'(b0.rs_ready_o[1]), 64'h0);
    chk("x9_wb_data_nob",  64'(b0.rs_data_o[1]),  64'h0);
    cyc();
    idle();
    #1;
    chk("x9_after_ready_nob", 64'(b0.rs_ready_o[1]), 64'h1);
    chk("x9_after_data_nob",  64'(b0.rs_data_o[1]),  64'h55);
    chk("x9_after_busy",      64'(b1.busy_o),        64'h0);

    // Allocate and write x3 in the same cycle: allocation wins
    rs_addr[0] = 5'd3; rs_addr[1] = 5'd4;
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h33;
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    cyc();
    idle();
    #1;
    chk("x3_busy_byp",  64'(b1.busy_o),        64'h0000_0008);
    chk("x3_busy_nob",  64'(b0.busy_o),        64'h0000_0008);
    chk("x3_ready_byp", 64'(b1.rs_ready_o),    64'h2);
    chk("x3_data_nob",  64'(b0.rs_data_o[0]),  64'h33);

    // Flush beats a simultaneous allocation of x4
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_addr = 5'd4;
    cyc();
    idle();
    #1;
    chk("flush_busy_byp",  64'(b1.busy_o),     64'h0);
    chk("flush_busy_nob",  64'(b0.busy_o),     64'h0);
    chk("flush_ready_nob", 64'(b0.rs_ready_o), 64'h3);
    chk("flush_keep_x3",   64'(b1.rs_data_o[0]), 64'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
